// File: rtl/core_fetch.sv
// Instruction fetch front end: issues in-order imem requests, buffers responses, and feeds the IF/ID register.
// Optional macro FETCH_MISALIGN_EXC_EN turns a misaligned target into a single IF_misalign entry instead of aligning it.
module core_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] next_pc,
   input  logic        flush,
   input  logic        stall,
   output logic [63:0] pc,
   output logic [63:0] pc4,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        IF_valid,
   output logic [63:0] IF_pc,
   output logic [31:0] IF_inst
`ifdef FETCH_MISALIGN_EXC_EN
  ,output logic        IF_misalign
`endif
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = CW + 2;

   logic [63:0]   pc_q, pc_d;
   logic [PW-1:0] wr_q, wr_d, rsp_q, rsp_d, rd_q, rd_d;
   logic [CW-1:0] out_q, out_d, buf_q, buf_d, disc_q, disc_d;
   logic [63:0]   ent_pc_q [DEPTH];
   logic [63:0]   ent_pc_d [DEPTH];
   logic [31:0]   ent_inst_q [DEPTH];
   logic [31:0]   ent_inst_d [DEPTH];
   logic          if_valid_q, if_valid_d;
   logic [63:0]   if_pc_q, if_pc_d;
   logic [31:0]   if_inst_q, if_inst_d;
`ifdef FETCH_MISALIGN_EXC_EN
   logic          ent_mis_q [DEPTH];
   logic          ent_mis_d [DEPTH];
   logic          if_mis_q, if_mis_d;
   logic          halt_q, halt_d;
`endif

   logic          pop, rsp_live, accept, inject, room, no_fetch;
   logic [SW-1:0] load;
   logic [63:0]   np_fix;

   // One ring holds every slot: [rd,rsp) are buffered responses, [rsp,wr) are live requests.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop      = ~stall & (buf_q != '0);
   assign rsp_live = imem_rvalid & (disc_q == '0);
   // A head popped this cycle frees its slot in time for a same-cycle request.
   assign load     = SW'(out_q) + SW'(disc_q) + SW'(buf_q) - SW'(pop);
   assign room     = load < SW'(DEPTH);

`ifdef FETCH_MISALIGN_EXC_EN
   assign no_fetch    = (pc_q[1:0] != 2'b00) | halt_q;
   assign np_fix      = next_pc;
   assign inject      = ~reset & ~flush & (pc_q[1:0] != 2'b00) & ~halt_q & (out_q == '0) & room;
   assign IF_misalign = if_mis_q;
`else
   assign no_fetch    = 1'b0;
   assign np_fix      = next_pc & ~64'h3;
   assign inject      = 1'b0;
`endif

   assign imem_req  = ~reset & ~flush & room & ~no_fetch;
   assign accept    = imem_req & imem_gnt;
   assign pc        = pc_q;
   assign pc4       = pc_q + 64'd4;
   assign imem_addr = pc_q;
   assign IF_valid  = if_valid_q;
   assign IF_pc     = if_pc_q;
   assign IF_inst   = if_inst_q;

   always_comb begin
      pc_d       = pc_q;
      wr_d       = wr_q;
      rsp_d      = rsp_q;
      rd_d       = rd_q;
      out_d      = out_q;
      buf_d      = buf_q;
      disc_d     = disc_q;
      ent_pc_d   = ent_pc_q;
      ent_inst_d = ent_inst_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
`ifdef FETCH_MISALIGN_EXC_EN
      ent_mis_d  = ent_mis_q;
      if_mis_d   = if_mis_q;
      halt_d     = halt_q;
`endif
      if (reset) begin
         pc_d       = RESET_PC;
         wr_d       = '0;
         rsp_d      = '0;
         rd_d       = '0;
         out_d      = '0;
         buf_d      = '0;
         disc_d     = '0;
         if_valid_d = 1'b0;
         if_pc_d    = '0;
         if_inst_d  = '0;
`ifdef FETCH_MISALIGN_EXC_EN
         if_mis_d   = 1'b0;
         halt_d     = 1'b0;
`endif
      end else if (flush) begin
         pc_d       = np_fix;
         wr_d       = '0;
         rsp_d      = '0;
         rd_d       = '0;
         out_d      = '0;
         buf_d      = '0;
         // Everything still in flight at the memory becomes a discard.
         disc_d     = disc_q + out_q - CW'(imem_rvalid);
         if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
         if_mis_d   = 1'b0;
         halt_d     = 1'b0;
`endif
      end else begin
         out_d = out_q + CW'(accept) - CW'(rsp_live);
         buf_d = buf_q + CW'(rsp_live) + CW'(inject) - CW'(pop);
         if (imem_rvalid && !rsp_live) disc_d = disc_q - CW'(1);
         if (accept) begin
            ent_pc_d[wr_q] = pc_q;
            wr_d           = inc(wr_q);
            pc_d           = np_fix;
`ifdef FETCH_MISALIGN_EXC_EN
            ent_mis_d[wr_q] = 1'b0;
`endif
         end
`ifdef FETCH_MISALIGN_EXC_EN
         if (inject) begin
            ent_pc_d[wr_q]   = pc_q;
            ent_inst_d[wr_q] = '0;
            ent_mis_d[wr_q]  = 1'b1;
            wr_d             = inc(wr_q);
            rsp_d            = inc(rsp_q);
            halt_d           = 1'b1;
         end
`endif
         if (rsp_live) begin
            ent_inst_d[rsp_q] = imem_rdata;
            rsp_d             = inc(rsp_q);
         end
         if (pop) begin
            if_valid_d = 1'b1;
            if_pc_d    = ent_pc_q[rd_q];
            if_inst_d  = ent_inst_q[rd_q];
            rd_d       = inc(rd_q);
`ifdef FETCH_MISALIGN_EXC_EN
            if_mis_d   = ent_mis_q[rd_q];
`endif
         end else if (!stall) begin
            if_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      pc_q       <= pc_d;
      wr_q       <= wr_d;
      rsp_q      <= rsp_d;
      rd_q       <= rd_d;
      out_q      <= out_d;
      buf_q      <= buf_d;
      disc_q     <= disc_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
`ifdef FETCH_MISALIGN_EXC_EN
      ent_mis_q  <= ent_mis_d;
      if_mis_q   <= if_mis_d;
      halt_q     <= halt_d;
`endif
   end
endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: directed scenarios then random traffic, checked against a queue-based fetch model.
`timescale 1ns/1ps
module tb_core_fetch;
   localparam int          DEPTH    = 2;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clock = 1'b0;
   logic        reset, flush, stall, imem_gnt, imem_rvalid;
   logic [63:0] next_pc, pc, pc4, imem_addr, IF_pc;
   logic [31:0] imem_rdata, IF_inst;
   logic        imem_req, IF_valid;
`ifdef FETCH_MISALIGN_EXC_EN
   logic        IF_misalign;
`endif

   always #5 clock = ~clock;

   core_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .next_pc(next_pc), .flush(flush), .stall(stall),
      .pc(pc), .pc4(pc4), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IF_valid(IF_valid), .IF_pc(IF_pc), .IF_inst(IF_inst)
`ifdef FETCH_MISALIGN_EXC_EN
     ,.IF_misalign(IF_misalign)
`endif
   );

   typedef struct { logic [63:0] addr; int rdy; bit dead; } mreq_t;
   typedef struct { logic [63:0] pc; logic [31:0] inst; bit mis; } ent_t;

   mreq_t       mem_q[$];   // requests sitting in the memory, in order
   ent_t        strm[$];    // fetched-but-not-presented instructions
   int          resp_cnt;   // how many at the front of strm already have their data
   int          cyc_n, n_tests, n_fail, lat;
   bit          synced;
   logic [63:0] exp_pc, exp_if_pc;
   logic [31:0] exp_if_inst;
   bit          exp_valid, exp_mis, exp_halt;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [63:0] align(input logic [63:0] a);
`ifdef FETCH_MISALIGN_EXC_EN
      return a;
`else
      return {a[63:2], 2'b00};
`endif
   endfunction

   function automatic int live_cnt();
      int c = 0;
      foreach (mem_q[i]) if (!mem_q[i].dead) c++;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive memory, check combinational outputs, advance model, check IF/ID at negedge.
   task automatic tick();
      bit pop, acc, rv, inj, nofetch, req_exp;
      int used;
      mreq_t h;
      ent_t  e;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (!reset && mem_q.size() > 0 && mem_q[0].rdy <= cyc_n) begin
         imem_rvalid = 1'b1;
         imem_rdata  = inst_of(mem_q[0].addr);
      end
      #1;
      assert (!(imem_rvalid && mem_q.size() == 0))
         else $error("FAIL rv_illegal: response with nothing outstanding");
      pop     = !stall && resp_cnt > 0;
      used    = mem_q.size() + resp_cnt - int'(pop);
      nofetch = (exp_pc[1:0] != 2'b00) || exp_halt;
      req_exp = !reset && !flush && !nofetch && used < DEPTH;
      inj     = !reset && !flush && exp_pc[1:0] != 2'b00 && !exp_halt && live_cnt() == 0 && used < DEPTH;
      if (synced) begin
         chk("imem_req", imem_req, req_exp);
         chk("pc", pc, exp_pc);
         chk("imem_addr", imem_addr, exp_pc);
         chk("pc4", pc4, exp_pc + 64'd4);
      end
      acc = req_exp && imem_gnt;
      rv  = imem_rvalid;
      @(posedge clock);
      cyc_n++;
      if (reset) begin
         mem_q.delete(); strm.delete();
         resp_cnt = 0; exp_pc = RESET_PC; exp_valid = 0; exp_if_pc = '0; exp_if_inst = '0;
         exp_mis = 0; exp_halt = 0; synced = 1;
      end else begin
         if (rv) begin
            h = mem_q.pop_front();
            if (!h.dead) resp_cnt++;
         end
         if (flush) begin
            foreach (mem_q[i]) mem_q[i].dead = 1;
            strm.delete();
            resp_cnt = 0; exp_pc = align(next_pc); exp_valid = 0; exp_mis = 0; exp_halt = 0;
         end else begin
            if (pop) begin
               e = strm.pop_front(); resp_cnt--;
               exp_valid = 1; exp_if_pc = e.pc; exp_if_inst = e.inst; exp_mis = e.mis;
            end else if (!stall) exp_valid = 0;
            if (acc) begin
               mem_q.push_back('{addr: exp_pc, rdy: cyc_n + lat - 1, dead: 1'b0});
               strm.push_back('{pc: exp_pc, inst: inst_of(exp_pc), mis: 1'b0});
               exp_pc = align(next_pc);
            end
            if (inj) begin
               strm.push_back('{pc: exp_pc, inst: 32'h0, mis: 1'b1});
               resp_cnt++; exp_halt = 1;
            end
         end
      end
      @(negedge clock);
      chk("IF_valid", IF_valid, exp_valid);
      if (exp_valid || reset) begin
         chk("IF_pc", IF_pc, exp_if_pc);
         chk("IF_inst", IF_inst, exp_if_inst);
      end
`ifdef FETCH_MISALIGN_EXC_EN
      chk("IF_misalign", IF_misalign, exp_mis);
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         next_pc = exp_pc + 64'd4;
         tick();
      end
   endtask

   task automatic wait_if(input int max);
      for (int i = 0; i < max && !IF_valid; i++) begin
         next_pc = exp_pc + 64'd4;
         tick();
      end
      chk("wait_if", IF_valid, 1'b1);
   endtask

   logic [63:0] held_pc;

   initial begin
      n_tests = 0; n_fail = 0; cyc_n = 0; resp_cnt = 0; synced = 0;
      exp_pc = RESET_PC; exp_valid = 0; exp_halt = 0; exp_mis = 0;
      reset = 1; flush = 0; stall = 0; imem_gnt = 0; next_pc = '0; lat = 1;
      imem_rvalid = 0; imem_rdata = '0;

      run(2);
      chk("rst_IF_valid", IF_valid, 1'b0);
      chk("rst_IF_pc", IF_pc, 64'h0);
      chk("rst_IF_inst", IF_inst, 32'h0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_req", imem_req, 1'b0);

      // straight-line fetch, 1-cycle memory
      reset = 0; imem_gnt = 1; lat = 1;
      run(2); chk("seq_c2_valid", IF_valid, 1'b0);
      run(1); chk("seq_c3_valid", IF_valid, 1'b1); chk("seq_c3_pc", IF_pc, 64'h0);
      run(1); chk("seq_c4_pc", IF_pc, 64'h4);
      run(1); chk("seq_c5_pc", IF_pc, 64'h8);

      // stall holds IF/ID while the buffer keeps 12 and 16
      stall = 1;
      for (int i = 0; i < 4; i++) begin
         run(1);
         chk("stall_hold_pc", IF_pc, 64'h8);
         chk("stall_hold_valid", IF_valid, 1'b1);
      end
      stall = 0;
      run(1); chk("unstall_pc12", IF_pc, 64'd12);
      run(1); chk("unstall_pc16", IF_pc, 64'd16);
      run(1); chk("unstall_pc20", IF_pc, 64'd20);

      // flush with two requests in flight
      lat = 3;
      for (int i = 0; i < 20 && live_cnt() != 2; i++) run(1);
      flush = 1; next_pc = 64'h100; tick(); flush = 0;
      chk("flush_valid0", IF_valid, 1'b0);
      wait_if(30);
      chk("flush_target", IF_pc, 64'h100);

      // flush colliding with a response while stalled
      for (int i = 0; i < 20 && !(live_cnt() == 2 && mem_q.size() == 2 && mem_q[0].rdy <= cyc_n); i++)
         run(1);
      stall = 1; flush = 1; next_pc = 64'h300; tick(); flush = 0;
      chk("flush_rv_valid0", IF_valid, 1'b0);
      run(2);
      chk("flush_rv_still0", IF_valid, 1'b0);
      stall = 0;
      wait_if(30);
      chk("flush_rv_target", IF_pc, 64'h300);

      // grant withheld for 10 cycles
      lat = 1; imem_gnt = 0; held_pc = exp_pc;
      run(10);
      chk("gnt_low_req", imem_req, 1'b1);
      chk("gnt_low_pc", pc, held_pc);
      chk("gnt_low_valid", IF_valid, 1'b0);
      imem_gnt = 1;
      wait_if(10);
      chk("gnt_resume_pc", IF_pc, held_pc);
      run(1);
      chk("gnt_resume_next", IF_pc, held_pc + 64'd4);

`ifdef FETCH_MISALIGN_EXC_EN
      flush = 1; next_pc = 64'h102; tick(); flush = 0;
      wait_if(20);
      chk("mis_pc", IF_pc, 64'h102);
      chk("mis_flag", IF_misalign, 1'b1);
      run(3);
      chk("mis_no_req", imem_req, 1'b0);
      flush = 1; next_pc = 64'h200; tick(); flush = 0;
      wait_if(20);
      chk("mis_resume", IF_pc, 64'h200);
      chk("mis_resume_flag", IF_misalign, 1'b0);
`endif

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         lat      = $urandom_range(1, 4);
         stall    = ($urandom % 10) < 3;
         imem_gnt = ($urandom % 10) < 7;
         flush    = ($urandom % 25) == 0;
         reset    = ($urandom % 120) == 0;
         if ($urandom % 2) next_pc = exp_pc + 64'd4;
         else              next_pc = {$urandom, $urandom};
         tick();
      end
      reset = 0; flush = 0; stall = 0; imem_gnt = 1;
      run(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
